// File: rtl/ifetch_if.sv
// Fetch-controller bus bundle: PC register loop, instruction-memory request/response,
// redirect input and the decode-side handshake.
interface ifetch_if;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        input  current_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, if_ready,
        output next_pc, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output current_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, if_ready,
        input  next_pc, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// In-order instruction-fetch controller: issues requests at current_pc, buffers returned
// words with their PCs, delivers them to decode and steers the PC register.
//
// state | meaning
// RUN   | no stale responses outstanding; responses fill the buffer
// DRAIN | drop_cnt > 0; responses from before a redirect are discarded
module ifetch_ctrl #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic      clk,
    input logic      reset,
    ifetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end

    typedef enum logic {RUN, DRAIN} mode_t;

    mode_t           mode;
    // Pointers carry one wrap bit so a fully allocated buffer is distinct from an empty one.
    logic [PW-1:0]   alloc_ptr, fill_ptr, head_ptr;
    logic [PW-1:0]   drop_cnt, drop_nxt;
    logic [PW-1:0]   count, unfilled;
    logic [31:0]     pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic            push, fill, pop;

    assign count    = alloc_ptr - head_ptr;
    assign unfilled = alloc_ptr - fill_ptr;

    assign bus.imem_req_valid = !reset && !bus.redirect_valid &&
                                (({1'b0, count} + {1'b0, drop_cnt}) < DEPTH_W);
    assign bus.imem_req_addr  = bus.current_pc;

    assign bus.if_valid = filled_q[head_ptr[AW-1:0]];
    assign bus.if_pc    = pc_q[head_ptr[AW-1:0]];
    assign bus.if_instr = instr_q[head_ptr[AW-1:0]];

    assign push = bus.imem_req_valid && bus.imem_req_ready;
    assign fill = bus.imem_rsp_valid && (mode == RUN) && !bus.redirect_valid;
    assign pop  = bus.if_valid && bus.if_ready;

    // A response arriving with the redirect is counted against the entries being abandoned.
    always_comb begin
        drop_nxt = drop_cnt;
        if (bus.redirect_valid)
            drop_nxt = drop_cnt + unfilled - {{(PW-1){1'b0}}, bus.imem_rsp_valid};
        else if (mode == DRAIN && bus.imem_rsp_valid)
            drop_nxt = drop_cnt - {{(PW-1){1'b0}}, 1'b1};
    end

    always_comb begin
        bus.next_pc = bus.current_pc;
        if (bus.redirect_valid)
            bus.next_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        else if (push)
            bus.next_pc = bus.current_pc + 32'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode      <= RUN;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            filled_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            drop_cnt <= drop_nxt;
            mode     <= (drop_nxt != '0) ? DRAIN : RUN;
            if (bus.redirect_valid) begin
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                head_ptr  <= '0;
                filled_q  <= '0;
            end else begin
                if (push) begin
                    pc_q[alloc_ptr[AW-1:0]]     <= bus.current_pc;
                    filled_q[alloc_ptr[AW-1:0]] <= 1'b0;
                    alloc_ptr                   <= alloc_ptr + 1'b1;
                end
                if (fill) begin
                    instr_q[fill_ptr[AW-1:0]]  <= bus.imem_rsp_data;
                    filled_q[fill_ptr[AW-1:0]] <= 1'b1;
                    fill_ptr                   <= fill_ptr + 1'b1;
                end
                if (pop) begin
                    filled_q[head_ptr[AW-1:0]] <= 1'b0;
                    head_ptr                   <= head_ptr + 1'b1;
                end
            end
        end
    end
endmodule
